// File: rtl/conv_stream_pipeline.sv
// Purpose: streaming 3x3 fixed-point convolution with two line buffers, a frame FSM, a double-buffered kernel and a FWFT output FIFO.
// Latency: 3 cycles from pixel accept to FIFO write (multiply, adder tree, round/saturate).
// Backpressure: o_data_ready drops when FIFO occupancy reaches PROG_FULL_THRESH and while the frame tail drains.
//
// Ports:
//   axi_clk / axi_reset_n          clock, async active-low reset
//   i_data_valid, i_data           input raster pixel stream (signed Q INTEGER_BITS.FIXED_POINT_BITS)
//   o_data_ready                   input ready
//   kernel_load, kernel_vals       one-cycle kernel capture pulse, 9 coefficients (k0 = top-left, row-major)
//   o_data_valid, o_data           output window stream (FIFO not empty / head entry)
//   i_data_ready                   downstream ready
//   o_intr                         one-cycle frame-done pulse
// Optional build macro: CONV_RELU_EN clamps negative results to zero before the FIFO.

// Small synchronous first-word-fall-through FIFO used for the output stage.
// Latency: head entry visible the cycle after the write edge.
// Backpressure: push into a full FIFO succeeds only together with a pop.
module conv_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_dat,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_dat,
   output logic [$clog2(DEPTH):0] o_cnt,
   output logic                   o_empty,
   output logic                   o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign w_pop   = i_pop && !o_empty;
   // When full, the slot being written is the one being read out this cycle.
   assign w_push  = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_dat;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   assign o_dat = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_cnt = r_cnt;
endmodule

module conv_stream_pipeline #(
   parameter int INTEGER_BITS     = 8,
   parameter int FIXED_POINT_BITS = 4,
   parameter int IMG_WIDTH        = 512,
   parameter int IMG_HEIGHT       = 512,
   parameter int OUT_FIFO_DEPTH   = 16,
   parameter int PROG_FULL_THRESH = 12
) (
   input  logic                                          axi_clk,
   input  logic                                          axi_reset_n,
   input  logic                                          i_data_valid,
   input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]      i_data,
   output logic                                          o_data_ready,
   input  logic                                          kernel_load,
   input  logic [9*(INTEGER_BITS+FIXED_POINT_BITS)-1:0]  kernel_vals,
   output logic                                          o_data_valid,
   output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]      o_data,
   input  logic                                          i_data_ready,
   output logic                                          o_intr
);
   localparam int DW  = INTEGER_BITS + FIXED_POINT_BITS;
   localparam int PW  = 2 * DW;
   localparam int SW  = 2 * DW + 4;
   localparam int CW  = $clog2(IMG_WIDTH);
   localparam int RW  = $clog2(IMG_HEIGHT);
   localparam int FCW = $clog2(OUT_FIFO_DEPTH) + 1;

   localparam logic [CW-1:0]        COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0]        COL_TWO  = CW'(2);
   localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0]        ROW_ONE  = RW'(1);
   localparam logic signed [SW-1:0] RND      = SW'((1 << FIXED_POINT_BITS) >> 1);
   localparam logic signed [SW-1:0] SAT_MAX  = SW'((1 << (DW - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN  = ~SAT_MAX;
   localparam logic signed [DW-1:0] K_ONE    = DW'(1 << FIXED_POINT_BITS);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_col;
   logic [RW-1:0]         r_row;
   logic                  r_rdy;
   logic                  r_intr;
   logic                  w_acc;
   logic                  w_col_last;
   logic                  w_row_last;
   logic                  w_launch;
   logic                  w_drain_done;

   logic [DW-1:0]         r_lb0 [IMG_WIDTH];   // row-2 pixels
   logic [DW-1:0]         r_lb1 [IMG_WIDTH];   // row-1 pixels
   logic [DW-1:0]         w_top;
   logic [DW-1:0]         w_mid;

   logic signed [DW-1:0]  r_win  [9];
   logic signed [DW-1:0]  r_kact [9];
   logic signed [DW-1:0]  r_ksh  [9];
   logic                  r_kpend;
   logic                  w_kcopy;

   logic                  r_v0;
   logic                  r_v1;
   logic                  r_v2;
   logic signed [PW-1:0]  r_prod [9];
   logic signed [SW-1:0]  r_sum;
   logic signed [SW-1:0]  w_sum;
   logic signed [SW-1:0]  w_rnd;
   logic signed [SW-1:0]  w_shr;
   logic [DW-1:0]         w_res;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic [FCW-1:0]        w_fifo_cnt;
   logic [FCW-1:0]        w_cnt_nxt;

   assign w_acc      = i_data_valid && r_rdy;
   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);
   assign w_top      = r_lb0[r_col];
   assign w_mid      = r_lb1[r_col];

   // ---------------- frame FSM ----------------
   always_comb begin
      w_state_nxt  = r_state;
      w_launch     = 1'b0;
      w_drain_done = 1'b0;
      case (r_state)
         S_IDLE:  if (w_acc) w_state_nxt = S_FILL;
         S_FILL:  if (w_acc && w_col_last && (r_row == ROW_ONE)) w_state_nxt = S_RUN;
         S_RUN: begin
            w_launch = w_acc && (r_col >= COL_TWO);
            if (w_acc && w_col_last && w_row_last) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!r_v0 && !r_v1 && !r_v2) begin
               w_drain_done = 1'b1;
               w_state_nxt  = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         r_state <= S_IDLE;
         r_col   <= '0;
         r_row   <= '0;
         r_rdy   <= 1'b0;
         r_intr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_intr  <= w_drain_done;
         // Ready is registered from next-cycle state and occupancy so it is low in reset.
         r_rdy   <= (w_state_nxt != S_DRAIN) && (w_cnt_nxt < FCW'(PROG_FULL_THRESH));
         if (w_acc) begin
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   // ---------------- line buffers and 3x3 window ----------------
   // Each column slot shifts down one row per accept: lb1 -> lb0, pixel -> lb1.
   always_ff @(posedge axi_clk) begin
      if (w_acc) begin
         r_lb0[r_col] <= w_mid;
         r_lb1[r_col] <= i_data;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         for (int i = 0; i < 9; i++) r_win[i] <= '0;
         r_v0 <= 1'b0;
      end else begin
         r_v0 <= w_launch;
         if (w_acc) begin
            for (int r = 0; r < 3; r++) begin
               r_win[r*3]   <= r_win[r*3+1];
               r_win[r*3+1] <= r_win[r*3+2];
            end
            r_win[2] <= w_top;
            r_win[5] <= w_mid;
            r_win[8] <= i_data;
         end
      end
   end

   // ---------------- kernel double buffer ----------------
   // Active kernel only changes while no window is in flight.
   assign w_kcopy = r_kpend && ((r_state == S_IDLE) || w_drain_done);

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         for (int i = 0; i < 9; i++) begin
            r_kact[i] <= (i == 4) ? K_ONE : '0;
            r_ksh[i]  <= (i == 4) ? K_ONE : '0;
         end
         r_kpend <= 1'b0;
      end else begin
         if (kernel_load) begin
            for (int i = 0; i < 9; i++) r_ksh[i] <= kernel_vals[i*DW +: DW];
         end
         if (w_kcopy) begin
            for (int i = 0; i < 9; i++) r_kact[i] <= r_ksh[i];
         end
         r_kpend <= kernel_load || (r_kpend && !w_kcopy);
      end
   end

   // ---------------- arithmetic pipeline ----------------
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < 9; i++) w_sum = w_sum + SW'(r_prod[i]);
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         for (int i = 0; i < 9; i++) r_prod[i] <= '0;
         r_sum <= '0;
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
      end else begin
         r_v1 <= r_v0;
         r_v2 <= r_v1;
         if (r_v0) begin
            for (int i = 0; i < 9; i++)
               r_prod[i] <= $signed(PW'(r_win[i])) * $signed(PW'(r_kact[i]));
         end
         if (r_v1) r_sum <= w_sum;
      end
   end

   // Round half-up, arithmetic shift, saturate; evaluated in the cycle before the FIFO write.
   always_comb begin
      w_rnd = r_sum + RND;
      w_shr = w_rnd >>> FIXED_POINT_BITS;
      if (w_shr > SAT_MAX)      w_res = SAT_MAX[DW-1:0];
      else if (w_shr < SAT_MIN) w_res = SAT_MIN[DW-1:0];
      else                      w_res = w_shr[DW-1:0];
`ifdef CONV_RELU_EN
      if (w_res[DW-1]) w_res = '0;
`endif
   end

   // ---------------- output FIFO ----------------
   assign w_push    = r_v2;
   assign w_pop     = !w_fifo_empty && i_data_ready;
   assign w_cnt_nxt = w_fifo_cnt + {{(FCW-1){1'b0}}, w_push} - {{(FCW-1){1'b0}}, w_pop};

   conv_fifo #(
      .WIDTH (DW),
      .DEPTH (OUT_FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (axi_clk),
      .i_rst_n (axi_reset_n),
      .i_push  (w_push),
      .i_dat   (w_res),
      .i_pop   (w_pop),
      .o_dat   (o_data),
      .o_cnt   (w_fifo_cnt),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   assign o_data_valid = !w_fifo_empty;
   assign o_data_ready = r_rdy;
   assign o_intr       = r_intr;
endmodule

// File: tb/tb_conv_stream_pipeline.sv
// Directed bench for conv_stream_pipeline at 4x4 frames; expected outputs queued at drive time.
module tb_conv_stream_pipeline;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 12;

   logic              axi_clk = 1'b0;
   logic              axi_reset_n;
   logic              i_data_valid;
   logic [DW-1:0]     i_data;
   logic              o_data_ready;
   logic              kernel_load;
   logic [9*DW-1:0]   kernel_vals;
   logic              o_data_valid;
   logic [DW-1:0]     o_data;
   logic              i_data_ready;
   logic              o_intr;

   conv_stream_pipeline #(
      .INTEGER_BITS     (8),
      .FIXED_POINT_BITS (4),
      .IMG_WIDTH        (W),
      .IMG_HEIGHT       (H),
      .OUT_FIFO_DEPTH   (16),
      .PROG_FULL_THRESH (12)
   ) dut (
      .axi_clk      (axi_clk),
      .axi_reset_n  (axi_reset_n),
      .i_data_valid (i_data_valid),
      .i_data       (i_data),
      .o_data_ready (o_data_ready),
      .kernel_load  (kernel_load),
      .kernel_vals  (kernel_vals),
      .o_data_valid (o_data_valid),
      .o_data       (o_data),
      .i_data_ready (i_data_ready),
      .o_intr       (o_intr)
   );

   always #5 axi_clk = ~axi_clk;

   int          checks = 0;
   int          failures = 0;
   logic [11:0] sb [$];
   logic [11:0] mon_exp;
   int          pix [W*H];
   int          kb [9];   // kernel the bench expects to be active
   int          kn [9];   // kernel about to be loaded
   int          cyc = 0;
   int          last_acc = 0;
   int          intr_cnt = 0;
   int          intr_cyc = 0;
   int          ovf = 0;
   int          hi;
   int          n0;

   always @(posedge axi_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: compare every popped sample against the scoreboard head.
   always @(negedge axi_clk) begin
      if (axi_reset_n) begin
         if (o_intr) begin
            intr_cnt++;
            intr_cyc = cyc;
         end
         if (axi_reset_n && dut.w_push && dut.w_fifo_full && !dut.w_pop) ovf++;
         if (o_data_valid && i_data_ready) begin
            if (sb.size() == 0) begin
               check("out_unexpected_sb_size", 32'(sb.size()), 32'd1);
            end else begin
               mon_exp = sb.pop_front();
               check("out_data", 32'(o_data), 32'(mon_exp));
            end
         end
      end
   end

   function automatic logic [11:0] conv_ref(input int r, input int c);
      int s;
      int res;
      s = 0;
      for (int k = 0; k < 9; k++)
         s += kb[k] * pix[(r - 1 + k / 3) * W + (c - 1 + k % 3)];
      res = (s + 8) >>> 4;
      if (res > 2047)  res = 2047;
      if (res < -2048) res = -2048;
`ifdef CONV_RELU_EN
      if (res < 0) res = 0;
`endif
      return 12'(res);
   endfunction

   function automatic logic [9*DW-1:0] kpack();
      logic [9*DW-1:0] v;
      for (int i = 0; i < 9; i++) v[i*DW +: DW] = 12'(kn[i]);
      return v;
   endfunction

   task automatic expect_frame();
      for (int r = 1; r < H - 1; r++)
         for (int c = 1; c < W - 1; c++)
            sb.push_back(conv_ref(r, c));
   endtask

   task automatic rand_pix();
      for (int i = 0; i < W*H; i++) pix[i] = int'($urandom_range(0, 4095)) - 2048;
   endtask

   task automatic fill_pix(input int v);
      for (int i = 0; i < W*H; i++) pix[i] = v;
   endtask

   task automatic set_kn(input int v, input bit ident);
      for (int i = 0; i < 9; i++) kn[i] = ident ? ((i == 4) ? 16 : 0) : v;
   endtask

   // Holds i_data until accepted; kernel_load is cleared after the first edge.
   task automatic send_one();
      bit got;
      got = 1'b0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge axi_clk);
         if (o_data_ready) got = 1'b1;
         @(posedge axi_clk);
         #1;
         kernel_load = 1'b0;
      end
      if (got) last_acc = cyc;
      check("accept_within_budget", 32'(got), 32'd1);
   endtask

   task automatic send_frame(input int load_at, input logic [9*DW-1:0] lv);
      for (int i = 0; i < W*H; i++) begin
         i_data       = 12'(pix[i]);
         i_data_valid = 1'b1;
         if (i == load_at) begin
            kernel_vals = lv;
            kernel_load = 1'b1;
         end
         send_one();
      end
      i_data_valid = 1'b0;
   endtask

   task automatic load_idle();
      @(posedge axi_clk); #1;
      kernel_vals = kpack();
      kernel_load = 1'b1;
      @(posedge axi_clk); #1;
      kernel_load = 1'b0;
      repeat (2) @(posedge axi_clk);
      #1;
      for (int i = 0; i < 9; i++) kb[i] = kn[i];
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || o_data_valid) && n < 500) begin
         @(negedge axi_clk);
         n++;
      end
      check("drain_sb_empty", 32'(sb.size()), 32'd0);
      @(posedge axi_clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      axi_reset_n  = 1'b0;
      i_data_valid = 1'b0;
      i_data       = '0;
      kernel_load  = 1'b0;
      kernel_vals  = '0;
      i_data_ready = 1'b1;
      repeat (3) @(negedge axi_clk);
      check("rst_o_data_ready", 32'(o_data_ready), 32'd0);
      check("rst_o_data_valid", 32'(o_data_valid), 32'd0);
      check("rst_o_data",       32'(o_data),       32'd0);
      check("rst_o_intr",       32'(o_intr),       32'd0);
      axi_reset_n = 1'b1;
      @(posedge axi_clk); #1;

      // Identity kernel after reset, pixels 0..15 as integers.
      for (int i = 0; i < W*H; i++) pix[i] = i * 16;
      set_kn(0, 1'b1);
      for (int i = 0; i < 9; i++) kb[i] = kn[i];
      sb.push_back(12'h050); sb.push_back(12'h060);
      sb.push_back(12'h090); sb.push_back(12'h0A0);
      n0 = intr_cnt;
      send_frame(-1, '0);
      for (int n = 0; n < 100 && intr_cnt == n0; n++) @(negedge axi_clk);
      check("intr_seen", 32'(intr_cnt - n0), 32'd1);
      check("intr_latency_ge3", 32'((intr_cyc - last_acc) >= 3), 32'd1);
      wait_drain();
      check("intr_single_cycle", 32'(intr_cnt - n0), 32'd1);

      // All-ones kernel on unit pixels.
      set_kn(16, 1'b0); load_idle();
      fill_pix(16);
      repeat (4) sb.push_back(12'h090);
      send_frame(-1, '0); wait_drain();

      // Rounding: 9*8 + 8 >> 4 = 5.
      set_kn(8, 1'b0); load_idle();
      fill_pix(1);
      repeat (4) sb.push_back(12'h005);
      send_frame(-1, '0); wait_drain();

      // Saturation both ways.
      set_kn(16, 1'b0); load_idle();
      fill_pix(12'h7F0);
      repeat (4) sb.push_back(12'h7FF);
      send_frame(-1, '0); wait_drain();
      fill_pix(-2048);
`ifdef CONV_RELU_EN
      repeat (4) sb.push_back(12'h000);
`else
      repeat (4) sb.push_back(12'h800);
`endif
      send_frame(-1, '0); wait_drain();

      // Random kernel and pixels through the reference model.
      for (int i = 0; i < 9; i++) kn[i] = int'($urandom_range(0, 127)) - 64;
      load_idle();
      rand_pix(); expect_frame();
      send_frame(-1, '0); wait_drain();

      // Kernel load during row 2 must not affect the current frame.
      set_kn(0, 1'b1); load_idle();
      for (int i = 0; i < W*H; i++) pix[i] = i * 16;
      sb.push_back(12'h050); sb.push_back(12'h060);
      sb.push_back(12'h090); sb.push_back(12'h0A0);
      set_kn(16, 1'b0);
      send_frame(2 * W, kpack()); wait_drain();
      sb.push_back(12'h2D0); sb.push_back(12'h360);
      sb.push_back(12'h510); sb.push_back(12'h5A0);
      send_frame(-1, '0); wait_drain();
      for (int i = 0; i < 9; i++) kb[i] = 16;

      // Downstream stalled: three frames fill the FIFO to the threshold.
      i_data_ready = 1'b0;
      for (int f = 0; f < 3; f++) begin
         rand_pix(); expect_frame(); send_frame(-1, '0);
      end
      repeat (10) @(negedge axi_clk);
      check("bp_ready_low", 32'(o_data_ready), 32'd0);
      check("bp_valid_high", 32'(o_data_valid), 32'd1);
      rand_pix(); expect_frame();
      i_data = 12'(pix[0]); i_data_valid = 1'b1;
      hi = 0;
      repeat (20) begin
         @(negedge axi_clk);
         if (o_data_ready) hi++;
      end
      check("bp_held_off", 32'(hi), 32'd0);
      @(posedge axi_clk); #1;
      i_data_ready = 1'b1;
      send_frame(-1, '0); wait_drain();

      // Reset pulse mid-RUN with results sitting in the FIFO.
      i_data_ready = 1'b0;
      rand_pix();
      for (int i = 0; i < 14; i++) begin
         i_data = 12'(pix[i]); i_data_valid = 1'b1; send_one();
      end
      i_data_valid = 1'b0;
      repeat (6) @(negedge axi_clk);
      check("pre_rst_fifo_nonempty", 32'(o_data_valid), 32'd1);
      axi_reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(o_data_valid), 32'd0);
      check("mid_rst_data",  32'(o_data),       32'd0);
      check("mid_rst_ready", 32'(o_data_ready), 32'd0);
      @(negedge axi_clk);
      axi_reset_n  = 1'b1;
      i_data_ready = 1'b1;
      hi = 0;
      repeat (8) begin
         @(negedge axi_clk);
         if (o_data_valid) hi++;
      end
      check("post_rst_fifo_empty", 32'(hi), 32'd0);
      set_kn(0, 1'b1);
      for (int i = 0; i < 9; i++) kb[i] = kn[i];
      rand_pix(); expect_frame();
      @(posedge axi_clk); #1;
      send_frame(-1, '0); wait_drain();

      check("fifo_overflow_events", 32'(ovf), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
